// File: rtl/mole_pkg.sv
// Shared constants and the LFSR step function for the whack-a-mole field.
package mole_pkg;

  localparam int unsigned LFSR_W         = 16;
  localparam int unsigned AGE_W          = 4;
  localparam int unsigned SPEEDUP_STEP   = 8;
  localparam int unsigned LIFETIME_FLOOR = 2;

  // Galois taps 16,14,13,11 for a right-shifting register
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR that steps once per advance strobe.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/mole_field.sv
// Whack-a-mole playfield: spawns, ages, expires and clears moles per hole.
// Optional: define MOLE_FIELD_SPEEDUP_EN to shorten mole lifetime as hits accumulate.
module mole_field
  import mole_pkg::*;
#(
  parameter int unsigned       NUM_HOLES      = 18,
  parameter int unsigned       MAX_ACTIVE     = 3,
  parameter int unsigned       LIFETIME_TICKS = 8,
  parameter logic [LFSR_W-1:0] SEED           = DEFAULT_SEED
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mole_clk,
  input  logic [NUM_HOLES-1:0]           whack,
  output logic [NUM_HOLES-1:0]           mole_positions,
  output logic                           hit_pulse,
  output logic                           miss_pulse,
  output logic [$clog2(NUM_HOLES+1)-1:0] active_count
);

  localparam int unsigned CNT_W = $clog2(NUM_HOLES + 1);
  localparam int unsigned IDX_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

  logic                 mole_clk_q;
  logic [NUM_HOLES-1:0] pos_q, pos_d;
  logic [AGE_W-1:0]     age_q [NUM_HOLES];
  logic [AGE_W-1:0]     age_d [NUM_HOLES];
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 tick_c;
  logic [LFSR_W-1:0]    lfsr_value;
  logic [LFSR_W-1:0]    lfsr_next_c;
  logic [IDX_W-1:0]     cand_c;
  logic [AGE_W-1:0]     life_c;

  assign tick_c      = mole_clk & ~mole_clk_q;
  assign lfsr_next_c = lfsr_step(lfsr_value);
  assign cand_c      = IDX_W'(lfsr_next_c % LFSR_W'(NUM_HOLES));

  mole_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(tick_c),
    .value  (lfsr_value)
  );

`ifdef MOLE_FIELD_SPEEDUP_EN
  localparam int unsigned HIT_W = $clog2(SPEEDUP_STEP);

  logic [HIT_W-1:0] hits_q;
  logic [AGE_W-1:0] life_q;

  // Every SPEEDUP_STEP hit cycles, moles live one tick less (down to the floor)
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q <= '0;
      life_q <= AGE_W'(LIFETIME_TICKS);
    end else if (hit_d) begin
      hits_q <= hits_q + HIT_W'(1);
      if (hits_q == HIT_W'(SPEEDUP_STEP - 1) && life_q > AGE_W'(LIFETIME_FLOOR)) begin
        life_q <= life_q - AGE_W'(1);
      end
    end
  end

  assign life_c = life_q;
`else
  assign life_c = AGE_W'(LIFETIME_TICKS);
`endif

  // Resolve whacks and expiry first, then try to spawn into the freed field
  always_comb begin
    pos_d  = pos_q;
    age_d  = age_q;
    hit_d  = 1'b0;
    miss_d = 1'b0;
    cnt_d  = '0;

    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      if (pos_q[i]) begin
        if (whack[i]) begin
          pos_d[i] = 1'b0;
          hit_d    = 1'b1;
        end else if (tick_c) begin
          // >= keeps older moles expiring if the lifetime shrinks under them
          if (age_q[i] >= life_c - AGE_W'(1)) begin
            pos_d[i] = 1'b0;
            miss_d   = 1'b1;
          end else begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
      end
    end

    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      cnt_d = cnt_d + CNT_W'(pos_d[i]);
    end

    if (tick_c && !pos_d[cand_c] && !whack[cand_c] && cnt_d < CNT_W'(MAX_ACTIVE)) begin
      pos_d[cand_c] = 1'b1;
      age_d[cand_c] = '0;
      cnt_d         = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mole_clk_q <= 1'b1;
      pos_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < NUM_HOLES; i++) age_q[i] <= '0;
    end else begin
      mole_clk_q <= mole_clk;
      pos_q      <= pos_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      cnt_q      <= cnt_d;
      for (int unsigned i = 0; i < NUM_HOLES; i++) age_q[i] <= age_d[i];
    end
  end

  assign mole_positions = pos_q;
  assign hit_pulse      = hit_q;
  assign miss_pulse     = miss_q;
  assign active_count   = cnt_q;

endmodule

// File: tb/tb_mole_field.sv
// Scoreboard bench for mole_field: default lifetime and lifetime 15 side by side.
module tb_mole_field;

  logic        clk = 1'b0;
  logic        reset;
  logic        mole_clk;
  logic [17:0] whack;

  logic [17:0] pos0, pos1;
  logic        hit0, hit1, miss0, miss1;
  logic [4:0]  cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [17:0] pos;
    logic [4:0]  cnt;
    logic        hit;
    logic        miss;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  bit [17:0] m_pos  [2];
  int        m_age  [2][18];
  bit [15:0] m_lfsr [2];
  bit        m_mq   [2];

  always #5 clk = ~clk;

  mole_field u_dut0 (
    .clk           (clk),
    .reset         (reset),
    .mole_clk      (mole_clk),
    .whack         (whack),
    .mole_positions(pos0),
    .hit_pulse     (hit0),
    .miss_pulse    (miss0),
    .active_count  (cnt0)
  );

  mole_field #(.LIFETIME_TICKS(15)) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .mole_clk      (mole_clk),
    .whack         (whack),
    .mole_positions(pos1),
    .hit_pulse     (hit1),
    .miss_pulse    (miss1),
    .active_count  (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one field for one clk cycle
  function automatic exp_t model_step(input int m, input int lt, input bit rst,
                                      input bit mc, input bit [17:0] w);
    exp_t      e;
    bit        tk;
    bit        fb;
    int        cand;
    bit [17:0] np;
    e.hit  = 1'b0;
    e.miss = 1'b0;
    if (rst) begin
      m_pos[m]  = '0;
      m_lfsr[m] = 16'hACE1;
      m_mq[m]   = 1'b1;
      for (int i = 0; i < 18; i++) m_age[m][i] = 0;
    end else begin
      tk      = mc && !m_mq[m];
      m_mq[m] = mc;
      np      = m_pos[m];
      for (int i = 0; i < 18; i++) begin
        if (m_pos[m][i]) begin
          if (w[i]) begin
            np[i] = 1'b0;
            e.hit = 1'b1;
          end else if (tk) begin
            if (m_age[m][i] == lt - 1) begin
              np[i]  = 1'b0;
              e.miss = 1'b1;
            end else begin
              m_age[m][i]++;
            end
          end
        end
      end
      if (tk) begin
        fb        = m_lfsr[m][0];
        m_lfsr[m] = m_lfsr[m] >> 1;
        if (fb) m_lfsr[m] = m_lfsr[m] ^ 16'hB400;
        cand = int'(m_lfsr[m]) % 18;
        if (!np[cand] && !w[cand] && $countones(np) < 3) begin
          np[cand]       = 1'b1;
          m_age[m][cand] = 0;
        end
      end
      m_pos[m] = np;
    end
    e.pos = m_pos[m];
    e.cnt = 5'($countones(m_pos[m]));
    return e;
  endfunction

  // Called at posedge+2: drive one cycle, queue its expected result, return after it lands
  task automatic cycle(input bit rst, input bit mc, input bit [17:0] w);
    reset    = rst;
    mole_clk = mc;
    whack    = w;
    q0.push_back(model_step(0, 8, rst, mc, w));
    q1.push_back(model_step(1, 15, rst, mc, w));
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered output one step after the clk edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("mon0_pos",  32'(pos0),  32'(e.pos));
      chk("mon0_cnt",  32'(cnt0),  32'(e.cnt));
      chk("mon0_hit",  32'(hit0),  32'(e.hit));
      chk("mon0_miss", 32'(miss0), 32'(e.miss));
      chk("mon0_cap",  32'(cnt0 <= 5'd3), 32'd1);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("mon1_pos",  32'(pos1),  32'(e.pos));
      chk("mon1_cnt",  32'(cnt1),  32'(e.cnt));
      chk("mon1_hit",  32'(hit1),  32'(e.hit));
      chk("mon1_miss", 32'(miss1), 32'(e.miss));
      chk("mon1_cap",  32'(cnt1 <= 5'd3), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    mole_clk = 1'b0;
    whack    = '0;
    @(posedge clk);
    #2;

    cycle(1, 0, '0);
    cycle(1, 0, '0);
    repeat (10) cycle(0, 0, '0);
    chk("idle_pos",  32'(pos0),  32'h0);
    chk("idle_cnt",  32'(cnt0),  32'h0);
    chk("idle_hit",  32'(hit0),  32'h0);
    chk("idle_miss", 32'(miss0), 32'h0);

    // Tick 0: LFSR ACE1 -> E270, 57968 mod 18 = 8
    cycle(0, 1, '0);
    chk("first_pos0", 32'(pos0), 32'h00100);
    chk("first_cnt0", 32'(cnt0), 32'd1);
    chk("first_pos1", 32'(pos1), 32'h00100);
    cycle(0, 0, '0);

    // Ticks 1..8: spawns at 4 and 2 fill the field; hole 8 expires on tick 8, hole 0 respawns
    for (int t = 1; t <= 8; t++) begin
      cycle(0, 1, '0);
      if (t == 2) begin
        chk("full_pos0", 32'(pos0), 32'h00114);
        chk("full_cnt0", 32'(cnt0), 32'd3);
        chk("full_cnt1", 32'(cnt1), 32'd3);
      end
      if (t < 8) chk("early_miss0", 32'(miss0), 32'h0);
      if (t == 8) begin
        chk("expire_miss0", 32'(miss0), 32'h1);
        chk("expire_pos0",  32'(pos0),  32'h00015);
        chk("expire_pos1",  32'(pos1),  32'h00114);
        chk("expire_miss1", 32'(miss1), 32'h0);
      end
      cycle(0, 0, '0);
      if (t == 8) chk("miss_one_clk", 32'(miss0), 32'h0);
    end

    // Hold a whack on hole 4 for three clks
    cycle(0, 0, 18'h00010);
    chk("whack_hit0", 32'(hit0), 32'h1);
    chk("whack_pos0", 32'(pos0), 32'h00005);
    chk("whack_pos1", 32'(pos1), 32'h00104);
    chk("whack_hit1", 32'(hit1), 32'h1);
    cycle(0, 0, 18'h00010);
    chk("whack_hold_hit0", 32'(hit0), 32'h0);
    cycle(0, 0, 18'h00010);
    chk("whack_hold2_hit0", 32'(hit0), 32'h0);

    // Whack on an empty hole
    cycle(0, 0, 18'h20000);
    chk("empty_pos0", 32'(pos0), 32'h00005);
    chk("empty_hit0", 32'(hit0), 32'h0);

    // Tick 9: candidate 9
    cycle(0, 1, '0);
    chk("t9_pos0", 32'(pos0), 32'h00205);
    chk("t9_pos1", 32'(pos1), 32'h00304);
    cycle(0, 0, '0);

    // Tick 10: hole 2 expires in field 0 but is whacked; candidate 2 is whacked so no spawn
    cycle(0, 1, 18'h00004);
    chk("coinc_hit0",  32'(hit0),  32'h1);
    chk("coinc_miss0", 32'(miss0), 32'h0);
    chk("coinc_pos0",  32'(pos0),  32'h00201);
    chk("coinc_pos1",  32'(pos1),  32'h00300);
    cycle(0, 0, '0);

    // Tick 11: candidate 10, three moles visible; keep mole_clk high into reset
    cycle(0, 1, '0);
    chk("t11_pos0", 32'(pos0), 32'h00601);
    chk("t11_cnt0", 32'(cnt0), 32'd3);
    cycle(1, 1, '1);
    chk("rst_pos0",  32'(pos0),  32'h0);
    chk("rst_cnt0",  32'(cnt0),  32'h0);
    chk("rst_hit0",  32'(hit0),  32'h0);
    chk("rst_miss0", 32'(miss0), 32'h0);
    chk("rst_pos1",  32'(pos1),  32'h0);
    cycle(0, 1, '1);
    chk("post_rst_hit0", 32'(hit0), 32'h0);
    repeat (2) cycle(0, 1, '0);
    chk("no_tick_high", 32'(pos0), 32'h0);
    cycle(0, 0, '0);
    cycle(0, 1, '0);
    chk("respawn_pos0", 32'(pos0), 32'h00100);
    cycle(0, 0, '0);

    // Long run: expiries, respawns and the active cap across both lifetimes
    for (int k = 0; k < 24; k++) begin
      cycle(0, 1, '0);
      if (k == 1) chk("cap_cnt1", 32'(cnt1), 32'd3);
      cycle(0, 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
